// File: rtl/display_source_scheduler.sv
// Time-shares one 4-digit display between four value sources: round-robin on a dwell
// timer with urgent preemption, plus the 20 kHz refresh clock for display_controller.
module display_source_scheduler #(
  parameter int unsigned CLK_DIV     = 2500,
  parameter int unsigned DWELL_TICKS = 40000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  src_req,
  input  logic [51:0] src_num,
  input  logic [3:0]  urgent,
  input  logic        hold,
  output logic        clk_20k,
  output logic [12:0] number,
  output logic [1:0]  src_sel,
  output logic        blank,
  output logic        switch_pulse
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

  typedef enum logic [1:0] {StIdle, StShow, StUrgent} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] count_q;
  logic          clk_q;
  logic          tick;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [1:0]    sel_q, sel_d;
  logic          blank_q, blank_d;
  logic [12:0]   number_q, number_d;
  logic          pulse_q, pulse_d;

  // Lowest set bit; callers only use it when some bit is set.
  function automatic logic [1:0] lowest(input logic [3:0] v);
    lowest = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (v[i]) lowest = 2'(i);
    end
  endfunction

  // First requester after base in cyclic order; base itself if nobody else requests.
  function automatic logic [1:0] next_req(input logic [1:0] base, input logic [3:0] req);
    logic [1:0] idx;
    next_req = base;
    for (int i = 3; i >= 1; i--) begin
      idx = base + 2'(i);
      if (req[idx]) next_req = idx;
    end
  endfunction

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q <= '0;
      clk_q   <= 1'b0;
    end else begin
      count_q <= (count_q == CW'(CLK_DIV - 1)) ? '0 : count_q + 1'b1;
      if (count_q == '0) clk_q <= ~clk_q;
    end
  end

  assign tick = (count_q == '0) && !clk_q;

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    sel_d   = sel_q;
    blank_d = blank_q;
    if (urgent != 4'b0) begin
      state_d = StUrgent;
      sel_d   = lowest(urgent);
      blank_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          blank_d = 1'b1;
          if (src_req != 4'b0) begin
            state_d = StShow;
            sel_d   = lowest(src_req);
            dwell_d = '0;
            blank_d = 1'b0;
          end
        end
        StShow: begin
          if (!src_req[sel_q]) begin
            dwell_d = '0;
            if (src_req == 4'b0) begin
              state_d = StIdle;
              blank_d = 1'b1;
            end else begin
              sel_d = next_req(sel_q, src_req);
            end
          end else if (tick && !hold) begin
            if (dwell_q == DW'(DWELL_TICKS - 1)) begin
              dwell_d = '0;
              sel_d   = next_req(sel_q, src_req);
            end else begin
              dwell_d = dwell_q + 1'b1;
            end
          end
        end
        StUrgent: begin
          dwell_d = '0;
          if (src_req == 4'b0) begin
            state_d = StIdle;
            blank_d = 1'b1;
          end else begin
            state_d = StShow;
            sel_d   = next_req(sel_q, src_req);
          end
        end
        default: state_d = StIdle;
      endcase
    end
    // Blank wins over the source value in the same cycle it asserts.
    number_d = blank_d ? 13'd0 : src_num[int'(sel_q) * 13 +: 13];
    pulse_d  = (sel_d != sel_q) || (blank_d != blank_q);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= StIdle;
      dwell_q  <= '0;
      sel_q    <= 2'd0;
      blank_q  <= 1'b1;
      number_q <= 13'd0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      dwell_q  <= dwell_d;
      sel_q    <= sel_d;
      blank_q  <= blank_d;
      number_q <= number_d;
      pulse_q  <= pulse_d;
    end
  end

  assign clk_20k      = clk_q;
  assign number       = number_q;
  assign src_sel      = sel_q;
  assign blank        = blank_q;
  assign switch_pulse = pulse_q;

endmodule

// File: tb/tb_display_source_scheduler.sv
// Directed bench for display_source_scheduler with CLK_DIV=4, DWELL_TICKS=3:
// ticks land on edges 1, 9, 17, ... after reset release, so a dwell spans 24 edges.
module tb_display_source_scheduler;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [3:0]  src_req = 4'b0;
  logic [51:0] src_num;
  logic [3:0]  urgent = 4'b0;
  logic        hold = 1'b0;
  logic        clk_20k;
  logic [12:0] number;
  logic [1:0]  src_sel;
  logic        blank;
  logic        switch_pulse;

  int total = 0;
  int bad = 0;
  int edge_n = 0;
  int pulse_cnt = 0;

  display_source_scheduler #(
    .CLK_DIV    (4),
    .DWELL_TICKS(3)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .src_req     (src_req),
    .src_num     (src_num),
    .urgent      (urgent),
    .hold        (hold),
    .clk_20k     (clk_20k),
    .number      (number),
    .src_sel     (src_sel),
    .blank       (blank),
    .switch_pulse(switch_pulse)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One posedge, then observe at the following negedge.
  task automatic step();
    @(posedge CLK);
    edge_n++;
    @(negedge CLK);
    if (switch_pulse) pulse_cnt++;
  endtask

  task automatic run_to(input int n);
    while (edge_n < n) step();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b1;
    #2;
    check("rst_clk20k", int'(clk_20k), 0);
    check("rst_sel", int'(src_sel), 0);
    check("rst_blank", int'(blank), 1);
    check("rst_number", int'(number), 0);
    check("rst_pulse", int'(switch_pulse), 0);
    @(negedge CLK);
    RESET = 1'b0;
    edge_n = 0;
    pulse_cnt = 0;
  endtask

  initial begin
    src_num = {13'd400, 13'd300, 13'd200, 13'd100};

    // Divider: high after edges 1-4, low after 5-8, period 8.
    do_reset();
    for (int k = 1; k <= 11; k++) begin
      step();
      check($sformatf("div_e%0d", k), int'(clk_20k), ((k - 1) / 4) % 2 == 0 ? 1 : 0);
    end
    check("idle_blank", int'(blank), 1);
    #2 RESET = 1'b1;
    #1 check("async_rst_clk", int'(clk_20k), 0);
    do_reset();
    step();
    check("div_restart", int'(clk_20k), 1);

    // Rotation over sources 0,1,3.
    src_req = 4'b1011;
    do_reset();
    step();
    check("rot_e1_sel", int'(src_sel), 0);
    check("rot_e1_blank", int'(blank), 0);
    check("rot_e1_pulse", int'(switch_pulse), 1);
    check("rot_e1_num", int'(number), 100);
    run_to(24);
    check("rot_e24_sel", int'(src_sel), 0);
    run_to(25);
    check("rot_e25_sel", int'(src_sel), 1);
    check("rot_e25_pulse", int'(switch_pulse), 1);
    run_to(26);
    check("rot_e26_num", int'(number), 200);
    check("rot_e26_pulse", int'(switch_pulse), 0);
    run_to(49);
    check("rot_e49_sel", int'(src_sel), 3);
    run_to(50);
    check("rot_e50_num", int'(number), 400);
    run_to(73);
    check("rot_e73_sel", int'(src_sel), 0);
    run_to(74);
    check("rot_e74_num", int'(number), 100);
    check("rot_pulses", pulse_cnt, 4);

    // Single requester never rotates away.
    src_req = 4'b0100;
    do_reset();
    step();
    check("single_sel", int'(src_sel), 2);
    run_to(60);
    check("single_sel_late", int'(src_sel), 2);
    check("single_num", int'(number), 300);
    check("single_pulses", pulse_cnt, 1);

    // Dropout mid-dwell (dwell=1 after edge 33).
    src_req = 4'b1011;
    do_reset();
    run_to(35);
    check("drop_pre_sel", int'(src_sel), 1);
    src_req = 4'b1001;
    step();
    check("drop_sel", int'(src_sel), 3);
    check("drop_pulse", int'(switch_pulse), 1);
    run_to(49);
    check("drop_dwell_reset", int'(src_sel), 3);
    run_to(57);
    check("drop_rotate", int'(src_sel), 0);
    src_req = 4'b0000;
    step();
    check("drop_idle_blank", int'(blank), 1);
    check("drop_idle_num", int'(number), 0);
    check("drop_idle_pulse", int'(switch_pulse), 1);

    // Urgent preemption and re-preemption by a lower index.
    src_req = 4'b1011;
    do_reset();
    run_to(10);
    urgent = 4'b1000;
    step();
    check("urg_sel3", int'(src_sel), 3);
    step();
    check("urg_num400", int'(number), 400);
    urgent = 4'b1010;
    step();
    check("urg_sel1", int'(src_sel), 1);
    step();
    check("urg_num200", int'(number), 200);
    urgent = 4'b0000;
    step();
    check("urg_resume", int'(src_sel), 3);
    run_to(32);
    check("urg_dwell_e32", int'(src_sel), 3);
    run_to(33);
    check("urg_dwell_e33", int'(src_sel), 0);

    // Hold freezes dwell at 1 across ten ticks, then counting resumes from 1.
    src_req = 4'b1011;
    do_reset();
    run_to(10);
    hold = 1'b1;
    run_to(90);
    check("hold_no_rot", int'(src_sel), 0);
    hold = 1'b0;
    run_to(104);
    check("hold_resume_e104", int'(src_sel), 0);
    run_to(105);
    check("hold_resume_e105", int'(src_sel), 1);
    hold = 1'b1;
    src_req = 4'b1001;
    step();
    check("hold_dropout", int'(src_sel), 3);
    hold = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/display_source_scheduler.md
Name: display_source_scheduler

Overview:
Shares the single 4-digit seven-segment display between four value sources, e.g. voltage readout, frequency readout, counter and debug value. It rotates round-robin among the requesting sources on a dwell timer and lets an urgent source preempt the rotation. It also generates the 20 kHz refresh clock for display_controller. Its number and clk_20k outputs feed display_controller directly.

Parameters:
CLK_DIV, 2500, CLK cycles per clk_20k half-period (100 MHz -> 20 kHz).
DWELL_TICKS, 40000, 20 kHz ticks each source is shown before rotating (2 s).

Ports:
CLK  input  1  system clock, 100 MHz.
RESET  input  1  asynchronous, active-high reset.
src_req  input  4  level request; bit i means source i wants display time.
src_num  input  52  packed source values; source i is bits [13i+12:13i], range 0..8191.
urgent  input  4  level preempt request per source; independent of src_req.
hold  input  1  freezes the dwell timer (no rotation while high).
clk_20k  output  1  refresh clock to display_controller.
number  output  13  value to display.
src_sel  output  2  index of the source currently shown.
blank  output  1  high when no source is shown.
switch_pulse  output  1  one-CLK pulse whenever src_sel changes or blank changes.

Behaviour:
- Reset values (asynchronous): div count=0, clk_20k=0, dwell=0, state=IDLE, src_sel=0, number=0, blank=1, switch_pulse=0.
- Divider: count runs 0..CLK_DIV-1 and wraps. clk_20k toggles on each CLK where count==0, giving a period of 2*CLK_DIV CLK cycles.
- tick: internal one-CLK pulse on the CLK where clk_20k toggles 0->1.
- Next requester: the first index after src_sel, in cyclic order, with src_req set. It is src_sel itself only if no other source requests.
- States:
  - IDLE: blank=1, number=0. When any src_req bit is set, the lowest requesting index is loaded into src_sel, dwell=0, and the state goes to SHOW.
  - SHOW:
    - On tick with hold=0, dwell increments.
    - When dwell reaches DWELL_TICKS-1 and a tick arrives, src_sel moves to the next requester and dwell=0.
    - If the next requester equals the current source: dwell=0, no switch_pulse.
    - If src_req[src_sel] drops: the next CLK switches to the next requester with dwell=0, or goes to IDLE if src_req==0.
  - URGENT: entered from IDLE or SHOW on the CLK after urgent!=0.
    - src_sel = lowest set urgent bit. Lower indices win and re-preempt immediately.
    - The dwell timer is frozen; hold has no effect here.
    - When urgent==0: resume SHOW at the next requester after the urgent index with dwell=0, or go to IDLE if src_req==0.
- Priority per CLK: urgent > requester dropout > dwell expiry > idle entry.
- hold:
  - Affects only dwell counting.
  - Dropout and urgent still act.
  - hold is sampled on ticks only.
- number: registered each CLK from src_num[src_sel] (live tracking), with one-CLK latency after a src_sel change. It is forced to 0 whenever blank=1.
- switch_pulse: asserted on the CLK in which the registered src_sel or blank changes. A reselection of the same index gives no pulse.
- RESET mid-operation: immediate return to reset values; clk_20k restarts at phase 0.

Test Plan:
All scenarios use CLK_DIV=4 and DWELL_TICKS=3, so a tick occurs every 8 CLK and a dwell lasts 24 CLK.
- Divider: RESET then free-run 40 CLK -> clk_20k toggles at count==0, period 8 CLK; RESET pulse at CLK 13 -> clk_20k=0 and count=0 asynchronously.
- Rotation: src_req=4'b1011, values 100/200/300/400, no urgent.
  - Required: src_sel sequence 0,1,3,0.
  - Each source held for 3 ticks; number=100,200,400,100.
  - One switch_pulse per change.
- Single source: src_req=4'b0100 -> src_sel=2 permanently, number=300, dwell restarts every 3 ticks, switch_pulse only on IDLE->SHOW.
- Dropout: showing src 1, src_req[1] deasserted mid-dwell -> src_sel=3 on the next CLK, dwell=0. Then src_req->0 -> IDLE, blank=1, number=0.
- Urgent: during SHOW of src 0, set urgent=4'b1000 -> src_sel=3 next CLK. Then set urgent=4'b1010 -> src_sel=1. Release urgent -> SHOW resumes at the next requester after 1.
- Hold: hold=1 for 10 ticks in SHOW -> no rotation. Dropping src_req[src_sel] during hold still switches. Releasing hold resumes counting from the frozen dwell value.
